// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   DIV_WIDTH_DEFAULT : default operand/result width in bits
//   div_state_t       : controller states (IDLE, BUSY, DONE)
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
// The partial remainder is shifted left one place and takes in the next
// dividend bit. If the shifted value is at least the divisor, the divisor is
// subtracted and the quotient bit is 1. Otherwise the shifted value passes
// through unchanged and the quotient bit is 0.
// Ports:
//   partial_in  [WIDTH:0]   partial remainder before this step
//   next_bit                next dividend bit, MSB first
//   divisor     [WIDTH-1:0] divisor
//   partial_out [WIDTH:0]   partial remainder after this step
//   q_bit                   quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   partial_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   partial_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] divisor_ext;

    always_comb begin
        shifted     = {partial_in, next_bit};
        divisor_ext = {2'b00, divisor};
        q_bit       = (shifted >= divisor_ext);
        // The stored partial remainder is always below the divisor, so the
        // restored or subtracted result always fits in WIDTH+1 bits.
        partial_out = q_bit ? (WIDTH+1)'(shifted - divisor_ext) : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned sequential restoring divider with valid/ready handshakes.
// A nonzero-divisor operation takes WIDTH iterations in BUSY, one per cycle.
// A zero divisor goes straight to DONE and returns quotient = all ones,
// remainder = dividend and div_by_zero = 1.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready is high only in IDLE)
//   dividend, divisor     unsigned operands, WIDTH bits each
//   out_valid / out_ready result handshake (out_valid is high only in DONE)
//   quotient, remainder   unsigned results, WIDTH bits each
//   div_by_zero           result was produced with divisor == 0
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned     CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t       state;
    div_state_t       next_state;
    logic [CNT_W-1:0] iter;
    logic             accept;

    // dq holds the dividend at accept. Each BUSY step shifts its MSB out into
    // the step logic and shifts the new quotient bit in at the LSB. After
    // WIDTH steps it holds the complete quotient.
    logic [WIDTH-1:0] dq;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] div_r;
    logic             dbz;

    logic [WIDTH:0]   step_partial;
    logic             step_q;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .partial_in  (partial),
        .next_bit    (dq[WIDTH-1]),
        .divisor     (div_r),
        .partial_out (step_partial),
        .q_bit       (step_q)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = (divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (iter == LAST_ITER) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Datapath: operand capture, iteration, and result hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter    <= '0;
            dq      <= '0;
            partial <= '0;
            div_r   <= '0;
            dbz     <= 1'b0;
        end else if (accept) begin
            iter  <= '0;
            div_r <= divisor;
            if (divisor == '0) begin
                dq      <= '1;
                partial <= {1'b0, dividend};
                dbz     <= 1'b1;
            end else begin
                dq      <= dividend;
                partial <= '0;
                dbz     <= 1'b0;
            end
        end else if (state == BUSY) begin
            iter    <= iter + CNT_W'(1);
            dq      <= {dq[WIDTH-2:0], step_q};
            partial <= step_partial;
        end
    end

    assign quotient    = dq;
    assign remainder   = partial[WIDTH-1:0];
    assign div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (WIDTH = 8). Expected results come from
// plain integer division in the reference functions below.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int unsigned W    = 8;
    localparam int unsigned MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int unsigned compared = 0;
    int unsigned mismatched = 0;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int unsigned ref_q(input int unsigned a, input int unsigned b);
        return (b == 0) ? MAXV : a / b;
    endfunction

    function automatic int unsigned ref_r(input int unsigned a, input int unsigned b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int unsigned ref_lat(input int unsigned b);
        return (b == 0) ? 1 : W + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One complete operation: accept, wait for the result (bounded), check it,
    // hold it under backpressure for 'hold' cycles, then hand it off.
    task automatic run_op(input int unsigned a, input int unsigned b,
                          input int unsigned hold, input string tag);
        int unsigned edges;
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        dividend  = W'(a);
        divisor   = W'(b);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        edges    = 1;
        in_valid = 1'b0;
        while (!out_valid && edges < 3 * W) begin
            // Operand activity while busy must not disturb the result
            in_valid = 1'($urandom_range(0, 1));
            dividend = W'($urandom);
            divisor  = W'($urandom);
            tick();
            edges++;
        end
        check({tag, ".latency"}, edges, ref_lat(b));
        check({tag, ".quotient"}, 32'(quotient), ref_q(a, b));
        check({tag, ".remainder"}, 32'(remainder), ref_r(a, b));
        check({tag, ".div_by_zero"}, 32'(div_by_zero), (b == 0) ? 32'd1 : 32'd0);
        check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
        for (int unsigned i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            dividend = W'($urandom);
            divisor  = W'($urandom);
            tick();
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_q"}, 32'(quotient), ref_q(a, b));
            check({tag, ".hold_r"}, 32'(remainder), ref_r(a, b));
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".handoff_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".handoff_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int unsigned seen;
        int unsigned base;
        int unsigned a;
        int unsigned b;

        // Reset state
        #12;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.quotient", 32'(quotient), 32'd0);
        check("reset.remainder", 32'(remainder), 32'd0);
        check("reset.div_by_zero", 32'(div_by_zero), 32'd0);
        #1;
        rst_n = 1'b1;

        // Directed operations; the first accept is the first edge after release
        run_op(200, 2, 0, "d200_2");
        run_op(255, 7, 0, "d255_7");
        run_op(5, 9, 0, "d5_9");
        run_op(13, 0, 0, "d13_0");
        run_op(100, 3, 5, "d100_3_bp");
        run_op(0, 1, 0, "d0_1");
        run_op(255, 1, 1, "d255_1");
        run_op(255, 255, 0, "d255_255");

        // Reset in the middle of an operation
        dividend = W'(100);
        divisor  = W'(3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.quotient", 32'(quotient), 32'd0);
        check("midrst.remainder", 32'(remainder), 32'd0);
        check("midrst.div_by_zero", 32'(div_by_zero), 32'd0);
        repeat (2) tick();
        #2;
        rst_n = 1'b1;
        seen = 0;
        repeat (3 * W) begin
            tick();
            if (out_valid) seen = 1;
        end
        check("midrst.no_result", seen, 32'd0);
        run_op(77, 7, 1, "after_rst");

        // Randomized operations
        for (int unsigned n = 0; n < 40; n++) begin
            a = $urandom_range(0, MAXV);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, MAXV);
            run_op(a, b, $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end

        // Back-to-back sweep with divisor 2
        base = mismatched;
        for (int unsigned d = 0; d <= MAXV; d++) begin
            run_op(d, 2, 0, $sformatf("sweep%0d", d));
            if (mismatched - base >= 5) break;
        end

        if (mismatched == 0) $display("TEST PASSED");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 8, is the operand and result width in bits; legal values are 2..32.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  producer offers dividend/divisor this cycle.
REQ-005 in_ready  out  1  block can accept operands; high only in IDLE.
REQ-006 dividend  in  WIDTH  unsigned numerator.
REQ-007 divisor  in  WIDTH  unsigned denominator.
REQ-008 out_valid  out  1  quotient/remainder/div_by_zero are valid; high only in DONE.
REQ-009 out_ready  in  1  consumer takes result this cycle.
REQ-010 quotient  out  WIDTH  unsigned floor(dividend/divisor).
REQ-011 remainder  out  WIDTH  unsigned dividend mod divisor.
REQ-012 div_by_zero  out  1  result was produced with divisor == 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 Accept: on a rising edge with in_valid && in_ready, the block SHALL latch dividend and divisor and leave IDLE.
REQ-015 With divisor != 0 at accept: IDLE->BUSY, iteration counter cleared.
REQ-016 BUSY: one restoring-division step per edge, MSB first; shift partial remainder left 1, bring in next dividend bit, subtract divisor when partial >= divisor, set quotient bit.
REQ-017 Partial remainder SHALL be WIDTH+1 bits internally so the shift never overflows.
REQ-018 After exactly WIDTH BUSY edges, BUSY->DONE; out_valid is first high WIDTH+1 edges after the accept edge.
REQ-019 With divisor == 0 at accept: IDLE->DONE on the accept edge; quotient = all ones, remainder = dividend, div_by_zero = 1 (latency 1 edge).
REQ-020 div_by_zero SHALL be 0 for every nonzero-divisor result.
REQ-021 DONE: outputs held stable while out_ready is low (indefinite backpressure).
REQ-022 DONE with out_ready high at an edge: DONE->IDLE; out_valid low and in_ready high after that edge.
REQ-023 No accept in the same cycle as result hand-off (in_ready is low in DONE); minimum issue interval is WIDTH+2 cycles.
REQ-024 in_valid, dividend and divisor SHALL be ignored outside IDLE; operand changes during BUSY do not affect the result.
REQ-025 quotient/remainder/div_by_zero SHALL be don't-care when out_valid is low, but are driven to 0 from reset until the first result.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-027 Reset asserted in BUSY or DONE SHALL abandon the operation with no result ever presented.
REQ-028 The first accept after reset release is permitted on the first rising edge with rst_n high.

Structure
REQ-029 Package div_pkg SHALL hold the default WIDTH constant and the state enum typedef (IDLE, BUSY, DONE).
REQ-030 Sub-module div_step (combinational, one restoring iteration: partial_in, next bit, divisor -> partial_out, q_bit) SHALL be instantiated once, used every BUSY cycle.
REQ-031 Iteration counter width SHALL be $clog2(WIDTH+1).

Verification
REQ-032 200/2, out_ready=1 -> out_valid 9 edges after accept, quotient=100, remainder=0, div_by_zero=0.
REQ-033 255/7 -> quotient=36, remainder=3; 5/9 -> quotient=0, remainder=5.
REQ-034 13/0 -> out_valid 1 edge after accept, quotient=255, remainder=13, div_by_zero=1.
REQ-035 100/3 with out_ready low 5 cycles after out_valid -> quotient=33, remainder=1 held stable; in_ready low throughout; IDLE one edge after out_ready rises.
REQ-036 rst_n pulsed low at BUSY iteration 4 -> out_valid never rises, in_ready=1 immediately; next op 77/7 -> 11 r 0.
REQ-037 Sweep dividend 0..255, divisor 2, back-to-back -> quotient == dividend/2, remainder == dividend%2, stop after 5 errors, print TEST PASSED on zero errors.
